ss_serializer_axis: RTL and testbench

- AXI-Stream width-down serializer. It is the transmit-side counterpart of the stream accumulator.
- Accepts one packed word of NO_OF_STEPS samples on the slave port and emits them as NO_OF_STEPS consecutive WIDTH-bit beats on the master port.
- m_last is asserted on the final beat.
- Sits between a word-wide producer and any sample-wide stream consumer, e.g. the accumulator's slave port.

---
 rtl/ss_axis_pkg.sv | 24 ++
 rtl/ss_beat_counter.sv | 42 ++++
 rtl/ss_serializer_axis.sv | 130 +++++++++++++
 tb/tb_ss_serializer_axis.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_axis_pkg.sv
// Shared types and helpers for the ss_* AXI-Stream blocks (serializer and accumulator).
package ss_axis_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ss_state_e;

  localparam int SS_DEF_WIDTH = 3;
  localparam int SS_DEF_STEPS = 4;

  typedef logic [SS_DEF_WIDTH-1:0]              ss_sample_t;
  typedef logic [SS_DEF_STEPS*SS_DEF_WIDTH-1:0] ss_word_t;

  function automatic int ss_cnt_width(input int steps);
    return (steps < 2) ? 1 : $clog2(steps);
  endfunction

  // Beat position to packed sample position; MSB-first walks the word downwards.
  function automatic int ss_sample_index(input int beat, input int steps, input bit msb_first);
    return msb_first ? (steps - 1 - beat) : beat;
  endfunction

endpackage

// File: rtl/ss_beat_counter.sv
// Saturating up-counter with clear and enable; exposes next value and next-terminal flag
// so the owner can register outputs that line up with the counter itself.
module ss_beat_counter #(
  parameter int MAX = 3,
  parameter int CW  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_next_o,
  output logic          tc_next_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise step while below terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CW{1'b0}};
    end else if (en_i && (cnt_q != CW'(MAX))) begin
      cnt_d = cnt_q + CW'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_next_o = cnt_d;
  assign tc_next_o  = (cnt_d == CW'(MAX));

endmodule

// File: rtl/ss_serializer_axis.sv
// AXI-Stream width-down serializer: one NO_OF_STEPS*WIDTH word in, NO_OF_STEPS beats out.
// Define SS_SER_MSB_FIRST_EN to emit the highest sample first.
module ss_serializer_axis
  import ss_axis_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int NO_OF_STEPS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [NO_OF_STEPS*WIDTH-1:0] s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [WIDTH-1:0]             m_data,
  output logic                         m_last
);

  localparam int CW = ss_cnt_width(NO_OF_STEPS);
  localparam int DW = NO_OF_STEPS * WIDTH;
`ifdef SS_SER_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  ss_state_e        state_q, state_d;
  logic [DW-1:0]    hold_q, hold_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             cnt_clr, cnt_en, tc_next;
  logic [CW-1:0]    cnt_next;
  logic             accept, beat_done;

  // A new word may only enter when idle or as the last beat of the current one leaves.
  assign s_ready   = (state_q == ST_IDLE) ? 1'b1 : (m_ready && m_last_q);
  assign accept    = s_valid && s_ready;
  assign beat_done = m_valid_q && m_ready;

  ss_beat_counter #(
    .MAX (NO_OF_STEPS - 1),
    .CW  (CW)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .cnt_next_o (cnt_next),
    .tc_next_o  (tc_next)
  );

  // Next state, holding register and counter control.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          hold_d  = s_data;
          cnt_clr = 1'b1;
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (accept) begin
          hold_d  = s_data;
          cnt_clr = 1'b1;
          state_d = ST_SEND;
        end else if (beat_done && m_last_q) begin
          state_d = ST_IDLE;
        end else if (beat_done) begin
          cnt_en  = 1'b1;
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output beat for the next cycle, built from next-state values so outputs stay registered.
  always_comb begin
    m_valid_d = (state_d == ST_SEND);
    m_data_d  = {WIDTH{1'b0}};
    m_last_d  = 1'b0;
    if (m_valid_d) begin
      for (int j = 0; j < NO_OF_STEPS; j++) begin
        if (cnt_next == CW'(j)) begin
          m_data_d = hold_d[ss_sample_index(j, NO_OF_STEPS, MSB_FIRST)*WIDTH +: WIDTH];
        end else begin
          m_data_d = m_data_d;
        end
      end
      m_last_d = tc_next;
    end else begin
      m_data_d = {WIDTH{1'b0}};
      m_last_d = 1'b0;
    end
  end

  // FSM state, holding register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hold_q    <= {DW{1'b0}};
      m_valid_q <= 1'b0;
      m_data_q  <= {WIDTH{1'b0}};
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_ss_serializer_axis.sv
// Scoreboard bench for ss_serializer_axis (WIDTH=3, NO_OF_STEPS=4); honours SS_SER_MSB_FIRST_EN.
module tb_ss_serializer_axis;

  localparam int WIDTH = 3;
  localparam int N     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [N*WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             l;
  } beat_t;
  beat_t q[$];

  always #5 clk = ~clk;

  ss_serializer_axis #(.WIDTH(WIDTH), .NO_OF_STEPS(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  function automatic void push_word(input logic [N*WIDTH-1:0] w);
    for (int j = 0; j < N; j++) begin
      int k;
`ifdef SS_SER_MSB_FIRST_EN
      k = N - 1 - j;
`else
      k = j;
`endif
      q.push_back('{d: w[k*WIDTH +: WIDTH], l: (j == N - 1)});
    end
  endfunction

  // Scoreboard consumer: every presented beat must match the queue head; pop on handshake.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst && m_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected: got data=%0d last=%0b, required no beat", m_data, m_last);
        end else begin
          if (m_data !== q[0].d || m_last !== q[0].l) begin
            bad++;
            $display("FAIL beat: got data=%0d last=%0b, required data=%0d last=%0b",
                     m_data, m_last, q[0].d, q[0].l);
          end
          if (m_ready) void'(q.pop_front());
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 3'd0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%0b l=%0b d=%0d, required 0 0 0", m_valid, m_last, m_data);
    end
    @(posedge clk); #2 rst = 1'b0;
    #1 total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_s_ready: got %0b required 1", s_ready);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (m_valid !== 1'b0 || m_data !== 3'd0 || s_ready !== 1'b1) begin
        bad++;
        $display("FAIL idle: got v=%0b d=%0d sr=%0b, required 0 0 1", m_valid, m_data, s_ready);
      end
    end
  endtask

  task automatic test_single_word();
    int n;
    @(posedge clk); #2 s_valid = 1'b1; s_data = 12'hFAC; m_ready = 1'b1;
    #2 total++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_accept: got sr=%0b v=%0b, required sr=1 v=0", s_ready, m_valid);
    end
    push_word(12'hFAC);
    @(posedge clk); #2 s_valid = 1'b0; s_data = 12'($urandom);
    total++;
    if (m_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_latency: got m_valid=%0b required 1", m_valid);
    end
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk); n++;
    end
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL single_cycles: got %0d cycles required 4", n);
    end
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_idle: got v=%0b sr=%0b, required v=0 sr=1", m_valid, s_ready);
    end
  endtask

  task automatic test_back_to_back();
    int  cyc;
    int  n;
    bit  sent2;
    bit  exp_sr;
    @(posedge clk); #2 s_valid = 1'b1; s_data = 12'hFAC; m_ready = 1'b1;
    #2 push_word(12'hFAC);
    @(posedge clk); #2 s_data = 12'h123;
    sent2 = 1'b0;
    cyc = 0;
    while (!sent2 && cyc < 10) begin
      #2 exp_sr = (q.size() == 1) && q[0].l;
      total++;
      if (s_ready !== exp_sr) begin
        bad++;
        $display("FAIL b2b_s_ready: cycle %0d got %0b required %0b", cyc, s_ready, exp_sr);
      end
      if (exp_sr) begin
        push_word(12'h123);
        sent2 = 1'b1;
      end
      @(posedge clk); cyc++; #2;
    end
    s_valid = 1'b0;
    total++;
    if (cyc != 4) begin
      bad++;
      $display("FAIL b2b_first_word: got %0d cycles required 4", cyc);
    end
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk); n++;
    end
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL b2b_second_word: got %0d cycles required 4", n);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit exp_sr;
    @(posedge clk); #2 s_valid = 1'b1; s_data = 12'hFAC; m_ready = 1'b1;
    #2 push_word(12'hFAC);
    @(posedge clk); #2 s_valid = 1'b0;
    cyc = 0;
    while (q.size() != 0 && cyc < 40) begin
      m_ready = (cyc % 3 == 0);
      s_data  = 12'($urandom);
      #2 exp_sr = m_ready && (q.size() == 1) && q[0].l;
      total++;
      if (s_ready !== exp_sr) begin
        bad++;
        $display("FAIL bp_s_ready: cycle %0d got %0b required %0b", cyc, s_ready, exp_sr);
      end
      @(posedge clk); #2 cyc++;
    end
    total++;
    if (cyc != 10) begin
      bad++;
      $display("FAIL bp_cycles: got %0d cycles required 10", cyc);
    end
    m_ready = 1'b1;
  endtask

  task automatic test_reset_mid_word();
    int n;
    @(posedge clk); #2 s_valid = 1'b1; s_data = 12'hFAC; m_ready = 1'b1;
    #2 push_word(12'hFAC);
    @(posedge clk); #2 s_valid = 1'b0;
    n = 0;
    while (q.size() != 2 && n < 20) begin
      @(posedge clk); n++;
    end
    #3 rst = 1'b1;
    #1 total++;
    if (m_valid !== 1'b0 || m_last !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: got v=%0b l=%0b, required 0 0", m_valid, m_last);
    end
    q.delete();
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b0;
    #1 total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_release_s_ready: got %0b required 1", s_ready);
    end
    @(posedge clk); #2 s_valid = 1'b1; s_data = 12'h123;
    #2 push_word(12'h123);
    @(posedge clk); #2 s_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk); n++;
    end
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL rst_next_word: got %0d cycles required 4", n);
    end
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 12'h000;
    m_ready = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_idle();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
